// File: rtl/sd_pkg.sv
// Shared types and constants for the SD bus arbiter (sd_bus_arb, sd_arb_cnt).
package sd_pkg;

  localparam int unsigned ENG_NUM   = 3;
  localparam int unsigned ENG_INIT  = 0;
  localparam int unsigned ENG_WRITE = 1;
  localparam int unsigned ENG_READ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/sd_arb_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module sd_arb_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sd_bus_arb.sv
// Arbitrates the SD card bus between init/write/read engines with a CSn-high gap.
// Optional grant timeout is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_bus_arb
  import sd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENG_NUM-1:0] req,
  input  logic [ENG_NUM-1:0] done,
  input  logic [ENG_NUM-1:0] mosi_in,
  input  logic [ENG_NUM-1:0] csn_in,
  output logic [ENG_NUM-1:0] gnt,
  output logic               sd_mosi,
  output logic               sd_csn,
  output logic               init_ok,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : $clog2(GAP_CYCLES + 1);

  arb_state_e         state_q, state_d;
  logic [ENG_NUM-1:0] gnt_q, gnt_d;
  logic [ENG_NUM-1:0] pend_q, pend_d;
  logic [ENG_NUM-1:0] eff_req;
  logic               init_ok_q, init_ok_d;
  logic               rr_read_q, rr_read_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_dec;
  logic               cnt_zero;
`ifdef SD_ARB_TIMEOUT_EN
  logic               timeout_err_q, timeout_err_d;
`endif

  sd_arb_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    pend_d    = pend_q;
    init_ok_d = init_ok_q;
    rr_read_d = rr_read_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    eff_req   = req | pend_q;
`ifdef SD_ARB_TIMEOUT_EN
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // rr_read_q set means read has priority on a write/read tie
        if (!init_ok_q) begin
          if (eff_req[ENG_INIT]) gnt_d = 3'b001;
        end else if (eff_req[ENG_WRITE] && (!eff_req[ENG_READ] || !rr_read_q)) begin
          gnt_d     = 3'b010;
          rr_read_d = 1'b1;
        end else if (eff_req[ENG_READ]) begin
          gnt_d     = 3'b100;
          rr_read_d = 1'b0;
        end
        if (gnt_d != '0) begin
          state_d = ST_GRANT;
          pend_d  = pend_q & ~gnt_d;
`ifdef SD_ARB_TIMEOUT_EN
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ST_GRANT: begin
        if ((done & gnt_q) != '0) begin
          gnt_d    = '0;
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(GAP_CYCLES - 1);
          if (gnt_q[ENG_INIT]) init_ok_d = 1'b1;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (cnt_zero) begin
          gnt_d         = '0;
          state_d       = ST_GAP;
          cnt_load      = 1'b1;
          cnt_val       = CNT_W'(GAP_CYCLES - 1);
          timeout_err_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        pend_d = pend_q | req;
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      pend_q    <= '0;
      init_ok_q <= 1'b0;
      rr_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      pend_q    <= pend_d;
      init_ok_q <= init_ok_d;
      rr_read_q <= rr_read_d;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    sd_mosi = 1'b1;
    sd_csn  = 1'b1;
    for (int unsigned i = 0; i < ENG_NUM; i++) begin
      if (gnt_q[i]) begin
        sd_mosi = mosi_in[i];
        sd_csn  = csn_in[i];
      end
    end
  end

  assign gnt     = gnt_q;
  assign init_ok = init_ok_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_bus_arb.sv
// Self-checking bench for sd_bus_arb: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_sd_bus_arb;

  localparam int G = 8;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] done = '0;
  logic [2:0] mosi_in = '0;
  logic [2:0] csn_in = 3'b111;
  logic [2:0] gnt;
  logic       sd_mosi, sd_csn, init_ok, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  sd_bus_arb #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .mosi_in     (mosi_in),
    .csn_in      (csn_in),
    .gnt         (gnt),
    .sd_mosi     (sd_mosi),
    .sd_csn      (sd_csn),
    .init_ok     (init_ok),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: current owner (-1 = none), remaining gap cycles, pending requests
  int       owner = -1;
  int       gap_left = 0;
  int       held = 0;
  int       last = 2;
  int       pick;
  bit [2:0] pend = '0;
  bit [2:0] eff;
  bit       m_init = 1'b0;
  bit       m_terr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1; gap_left = 0; held = 0; last = 2; pend = '0; m_init = 1'b0; m_terr = 1'b0;
    end else begin
      m_terr = 1'b0;
      if (owner >= 0) begin
        held++;
        if (done[owner]) begin
          if (owner == 0) m_init = 1'b1;
          owner = -1;
          gap_left = G;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (held == T) begin
          owner = -1;
          gap_left = G;
          m_terr = 1'b1;
        end
`endif
      end else if (gap_left > 0) begin
        pend |= req;
        gap_left--;
      end else begin
        eff = req | pend;
        pick = -1;
        if (!m_init) begin
          if (eff[0]) pick = 0;
        end else if (eff[1] && eff[2]) pick = (last == 1) ? 2 : 1;
        else if (eff[1]) pick = 1;
        else if (eff[2]) pick = 2;
        if (pick >= 0) begin
          owner = pick;
          held = 0;
          pend[pick] = 1'b0;
          if (pick != 0) last = pick;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt", {29'd0, gnt}, (owner >= 0) ? (32'd1 << owner) : 32'd0);
    chk("sd_csn", {31'd0, sd_csn}, (owner >= 0) ? {31'd0, csn_in[owner]} : 32'd1);
    chk("sd_mosi", {31'd0, sd_mosi}, (owner >= 0) ? {31'd0, mosi_in[owner]} : 32'd1);
    chk("init_ok", {31'd0, init_ok}, {31'd0, m_init});
    chk("busy", {31'd0, busy}, ((owner >= 0) || (gap_left > 0)) ? 32'd1 : 32'd0);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [2:0] g);
    g = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt !== 3'b000) begin
        g = gnt;
        return;
      end
    end
  endtask

  logic [2:0] g;
  int         n;

  initial begin
    @(posedge clk);
    #2;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_csn", {31'd0, sd_csn}, 32'd1);
    chk("rst_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("rst_init_ok", {31'd0, init_ok}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    rst = 1'b0; req = 3'b111; csn_in = 3'b110; mosi_in = 3'b001;
    @(posedge clk);
    @(negedge clk);
    chk("init_gnt", {29'd0, gnt}, 32'd1);
    chk("init_csn_lo", {31'd0, sd_csn}, 32'd0);
    nxt();
    csn_in = 3'b001; mosi_in = 3'b110;
    #1;
    chk("init_csn_hi", {31'd0, sd_csn}, 32'd1);
    chk("init_mosi", {31'd0, sd_mosi}, 32'd0);
    chk("init_only", {29'd0, gnt}, 32'd1);

    done = 3'b001; req = 3'b000;
    nxt();
    done = 3'b000;
    @(negedge clk);
    chk("done0_gnt", {29'd0, gnt}, 32'd0);
    chk("done0_init_ok", {31'd0, init_ok}, 32'd1);
    chk("done0_csn", {31'd0, sd_csn}, 32'd1);
    chk("gap_busy0", {31'd0, busy}, 32'd1);
    for (int k = 1; k < G; k++) begin
      @(negedge clk);
      chk("gap_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("gap_end_busy", {31'd0, busy}, 32'd0);

    nxt();
    req = 3'b110;
    wait_grant(g);
    chk("rr_first_write", {29'd0, g}, 32'd2);
    nxt(); done = 3'b100;
    nxt(); done = 3'b000;
    @(negedge clk);
    chk("foreign_done_ignored", {29'd0, gnt}, 32'd2);
    nxt(); done = 3'b010;
    nxt(); done = 3'b000;
    wait_grant(g);
    chk("rr_second_read", {29'd0, g}, 32'd4);
    nxt(); done = 3'b100;
    nxt(); done = 3'b000;
    wait_grant(g);
    chk("rr_third_write", {29'd0, g}, 32'd2);

    nxt();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", {29'd0, gnt}, 32'd0);
    chk("mid_rst_csn", {31'd0, sd_csn}, 32'd1);
    chk("mid_rst_init_ok", {31'd0, init_ok}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    nxt();
    rst = 1'b0; req = 3'b000;

`ifdef SD_ARB_TIMEOUT_EN
    nxt();
    req = 3'b001;
    wait_grant(g);
    chk("to_gnt", {29'd0, g}, 32'd1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt === 3'b000) break;
      n++;
    end
    chk("to_grant_len", n, T);
    chk("to_err_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_init_kept", {31'd0, init_ok}, 32'd0);
    @(negedge clk);
    chk("to_err_one_cycle", {31'd0, timeout_err}, 32'd0);
    wait_grant(g);
    chk("to_regrant", {29'd0, g}, 32'd1);
    for (int i = 0; i < T - 1; i++) @(posedge clk);
    #1;
    done = 3'b001; req = 3'b000;
    nxt();
    done = 3'b000;
    @(negedge clk);
    chk("to_done_last_gnt", {29'd0, gnt}, 32'd0);
    chk("to_done_last_err", {31'd0, timeout_err}, 32'd0);
    chk("to_done_last_init", {31'd0, init_ok}, 32'd1);
`endif

    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst     = ($urandom_range(0, 499) == 0);
      req     = 3'($urandom);
      done    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      mosi_in = 3'($urandom);
      csn_in  = 3'($urandom);
    end
    nxt();
    rst = 1'b0; req = '0; done = '0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_bus_arb.md
SD_BUS_ARB -- requirements
Module: sd_bus_arb

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 8, idle clk cycles with CSn high between transactions (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles one grant may be held (used only with SD_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  3  request per engine: bit0 init, bit1 write, bit2 read.
REQ-006 SHALL have port done  in  3  one-cycle completion pulse per engine.
REQ-007 SHALL have port mosi_in  in  3  per-engine MOSI.
REQ-008 SHALL have port csn_in  in  3  per-engine chip select, active-low.
REQ-009 SHALL have port gnt  out  3  one-hot grant, registered.
REQ-010 SHALL have port sd_mosi  out  1  muxed MOSI to card.
REQ-011 SHALL have port sd_csn  out  1  muxed chip select to card.
REQ-012 SHALL have port init_ok  out  1  sticky card-initialised flag.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port timeout_err  out  1  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement states IDLE, GRANT, GAP.
REQ-016 IDLE, init_ok=0: SHALL grant only bit0; req[2:1] ignored.
REQ-017 IDLE, init_ok=1: SHALL ignore req[0]; arbitrate bits 1/2 round-robin, write first after reset.
REQ-018 On a qualifying request in IDLE, gnt SHALL assert on the next clk edge and state SHALL become GRANT (1-cycle grant latency).
REQ-019 Simultaneous req[1] and req[2] SHALL grant the engine not served last; pointer updates on each grant.
REQ-020 GRANT: sd_mosi/sd_csn SHALL equal mosi_in/csn_in of the granted engine, combinationally from registered gnt.
REQ-021 Outside GRANT: sd_mosi=1, sd_csn=1.
REQ-022 Grant SHALL be held until done of the granted engine; done of non-granted engines SHALL be ignored; dropping req without done SHALL NOT release grant.
REQ-023 On granted done: gnt SHALL clear on the next edge; state -> GAP.
REQ-024 done[0] while init granted SHALL set init_ok on the same edge; init_ok SHALL remain 1 until reset.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE; requests during GAP SHALL be held pending, not lost.
REQ-026 busy SHALL be 1 in GRANT and GAP.

Reset
REQ-027 rst asserted SHALL immediately force: state IDLE, gnt=000, sd_csn=1, sd_mosi=1, init_ok=0, timeout_err=0, busy=0, counters 0, round-robin pointer to write.
REQ-028 Reset mid-GRANT SHALL abandon the transaction with no done or error pulse.

Configuration
REQ-029 With SD_ARB_TIMEOUT_EN defined: counter SHALL count GRANT cycles; at TIMEOUT_CYCLES without done, gnt SHALL clear, timeout_err SHALL pulse one cycle, state -> GAP, init_ok unchanged.
REQ-030 done and timeout in the same cycle SHALL be treated as done; no timeout_err.
REQ-031 Without SD_ARB_TIMEOUT_EN: no timeout counter; timeout_err tied 0; grant held indefinitely.

Structure
REQ-032 Shared package sd_pkg SHALL hold the state enum, engine index constants (ENG_INIT=0, ENG_WRITE=1, ENG_READ=2) and engine count 3.
REQ-033 Sub-module sd_arb_cnt (loadable down-counter with zero flag) SHALL serve the GAP and timeout counters.

Verification
REQ-034 Reset, req=111 -> gnt=001 one cycle later; sd_csn follows csn_in[0]; write/read not granted.
REQ-035 done[0] pulse -> init_ok=1, gnt=000, sd_csn=1 for 8 cycles, then IDLE.
REQ-036 init_ok=1, req=110 held -> grants alternate 010, 100, 010 across three done pulses.
REQ-037 Granted write, done[2] pulsed -> ignored; gnt stays 010.
REQ-038 Macro on, TIMEOUT_CYCLES=16, no done -> gnt clears after 16 GRANT cycles, timeout_err high one cycle; done on cycle 16 -> no error.
REQ-039 rst pulsed mid-GRANT -> gnt=000, sd_csn=1, init_ok=0 without waiting for clk.
